// File: rtl/mips_muldiv_unit_pkg.sv
// Shared definitions for the MIPS multiply/divide unit:
// ALU opcode numbers it answers to and FSM state encodings.
package mips_muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;

    // Same numbering as the ALU opcode map (SLL..UCMP)
    localparam logic [3:0] ALUOP_MULTU = 4'd3;
    localparam logic [3:0] ALUOP_DIVU  = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    function automatic logic is_muldiv_op(
        input logic [3:0] op,
        input logic [3:0] op_mul,
        input logic [3:0] op_div
    );
        return (op == op_mul) || (op == op_div);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_step.sv
// One combinational iteration of shift-add multiply or
// restoring divide on the {acc_hi, acc_lo} accumulator.
//
// Ports:
//   i_op      : opcode; OP_DIVU selects divide, anything else multiply
//   i_acc_hi  : P_hi (multiply) / remainder R (divide)
//   i_acc_lo  : P_lo (multiply) / quotient Q (divide)
//   i_operand : multiplicand X (multiply) / divisor Y (divide)
//   o_acc_hi  : next acc_hi
//   o_acc_lo  : next acc_lo
module muldiv_step
    import mips_muldiv_unit_pkg::*;
#(
    parameter int         WIDTH   = MD_WIDTH,
    parameter logic [3:0] OP_DIVU = ALUOP_DIVU
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);

    logic             w_is_div;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH+1:0] w_t;
    logic             w_fits;
    logic             w_unused_t;

    always_comb begin
        w_is_div = (i_op == OP_DIVU);

        // Multiply: conditional add with carry out into bit WIDTH
        w_sum = {1'b0, i_acc_hi};
        if (i_acc_lo[0]) begin
            w_sum = {1'b0, i_acc_hi} + {1'b0, i_operand};
        end

        // Divide: {R,Q} << 1, then trial subtract.
        // Kept R is always below the divisor (or equals the
        // shifted-in dividend prefix when Y=0), so WIDTH bits
        // of storage suffice; the shifted value needs WIDTH+1.
        w_shl      = {i_acc_hi, i_acc_lo[WIDTH-1]};
        w_t        = {1'b0, w_shl} - {2'b00, i_operand};
        w_fits     = ~w_t[WIDTH+1];
        w_unused_t = w_t[WIDTH];

        if (w_is_div) begin
            o_acc_hi = w_fits ? w_t[WIDTH-1:0] : w_shl[WIDTH-1:0];
            o_acc_lo = {i_acc_lo[WIDTH-2:0], w_fits};
        end else begin
            o_acc_hi = w_sum[WIDTH:1];
            o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit beside the ALU in EX,
// holding the architectural HI/LO registers.
//
// Ports:
//   LOGISIM_CLOCK_TREE_0 : clock tree bus, bit 4 is the clock
//   reset_n              : async active-low reset
//   start, AluOP, X, Y   : operation request
//   hi_we, lo_we, wdata  : MTHI/MTLO writes (honoured in IDLE)
//   HI, LO               : architectural registers
//   busy                 : operation in flight (RUN or FIN)
//   done                 : one-cycle pulse, HI/LO just written
module mips_muldiv_unit
    import mips_muldiv_unit_pkg::*;
#(
    parameter int         WIDTH    = MD_WIDTH,
    parameter logic [3:0] OP_MULTU = ALUOP_MULTU,
    parameter logic [3:0] OP_DIVU  = ALUOP_DIVU
) (
    input  logic [4:0]       LOGISIM_CLOCK_TREE_0,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       AluOP,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    wire w_clk = LOGISIM_CLOCK_TREE_0[4];
    wire w_unused_tree = ^LOGISIM_CLOCK_TREE_0[3:0];

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    assign w_accept = (r_state == ST_IDLE) && start
                      && is_muldiv_op(AluOP, OP_MULTU, OP_DIVU);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    muldiv_step #(
        .WIDTH   (WIDTH),
        .OP_DIVU (OP_DIVU)
    ) u_step (
        .i_op      (r_op),
        .i_acc_hi  (r_acc_hi),
        .i_acc_lo  (r_acc_lo),
        .i_operand (r_opnd),
        .o_acc_hi  (w_step_hi),
        .o_acc_lo  (w_step_lo)
    );

    always_ff @(posedge w_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_opnd   <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // MTHI/MTLO may share the edge with an accepted
                    // op; the op's result overwrites them at FIN.
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_accept) begin
                        r_op     <= AluOP;
                        r_cnt    <= '0;
                        r_acc_hi <= '0;
                        if (AluOP == OP_DIVU) begin
                            r_acc_lo <= X;
                            r_opnd   <= Y;
                        end else begin
                            r_acc_lo <= Y;
                            r_opnd   <= X;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + 1'b1;
                end
                ST_FIN: begin
                    r_hi   <= r_acc_hi;
                    r_lo   <= r_acc_lo;
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed corner
// cases plus random MULTU/DIVU against an arithmetic model.
module tb_mips_muldiv_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  AluOP;
    logic [31:0] X;
    logic [31:0] Y;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    exp_t        sbq[$];
    exp_t        last_e;
    int          checks = 0;
    int          errors = 0;
    int          since_acc = 0;
    int          busy_cnt = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mips_muldiv_unit dut (
        .LOGISIM_CLOCK_TREE_0 ({clk, 4'b0000}),
        .reset_n (reset_n),
        .start   (start),
        .AluOP   (AluOP),
        .X       (X),
        .Y       (Y),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .HI      (HI),
        .LO      (LO),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        if (op == 4'd3) begin
            p    = {32'd0, x} * {32'd0, y};
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 32'd0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
        end else begin
            e.hi = x % y;
            e.lo = x / y;
        end
        return e;
    endfunction

    // Monitor: compare HI/LO against the scoreboard on every done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("sb_hi", HI, e.hi);
                    check("sb_lo", LO, e.lo);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        since_acc++;
        if (busy) busy_cnt++;
    endtask

    task automatic accept(input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y);
        last_e = model(op, x, y);
        sbq.push_back(last_e);
        start = 1'b1;
        AluOP = op;
        X = x;
        Y = y;
        tick();
        since_acc = 0;
        busy_cnt = busy ? 1 : 0;
        check("busy_rise", {31'd0, busy}, 32'd1);
        start = 1'b0;
        X = $urandom;
        Y = $urandom;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && since_acc < 40) tick();
        check("done_lat", since_acc, 32'd33);
        check("busy_len", busy_cnt, 32'd33);
        check("busy_fall", {31'd0, busy}, 32'd0);
        m_hi = last_e.hi;
        m_lo = last_e.lo;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        reset_n = 1'b0;
        start = 1'b0;
        AluOP = 4'd0;
        X = '0;
        Y = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        tick();
        tick();
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        tick();

        accept(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        check("mul_max_hi", HI, 32'hFFFF_FFFE);
        check("mul_max_lo", LO, 32'h0000_0001);

        accept(4'd4, 32'd100, 32'd7);
        wait_done();
        check("div_lo", LO, 32'd14);
        check("div_hi", HI, 32'd2);

        accept(4'd4, 32'h1234_5678, 32'd0);
        wait_done();
        check("div0_lo", LO, 32'hFFFF_FFFF);
        check("div0_hi", HI, 32'h1234_5678);

        // Start while busy and MTLO while busy are both ignored
        accept(4'd3, 32'd3, 32'd5);
        while (since_acc < 10) tick();
        start = 1'b1;
        AluOP = 4'd3;
        X = 32'd7;
        Y = 32'd9;
        tick();
        start = 1'b0;
        check("busy_hold", {31'd0, busy}, 32'd1);
        lo_we = 1'b1;
        wdata = 32'h0000_ABCD;
        tick();
        lo_we = 1'b0;
        check("mtlo_busy", LO, m_lo);
        wait_done();
        check("mul35_hi", HI, 32'd0);
        check("mul35_lo", LO, 32'd15);

        // Asynchronous reset mid-run
        accept(4'd4, 32'hDEAD_0000, 32'd77);
        while (since_acc < 12) tick();
        reset_n = 1'b0;
        #1;
        check("arst_hi", HI, 32'd0);
        check("arst_lo", LO, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        sbq.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        reset_n = 1'b1;
        tick();
        accept(4'd4, 32'd9, 32'd3);
        wait_done();
        check("div93_lo", LO, 32'd3);
        check("div93_hi", HI, 32'd0);

        // Non-muldiv opcode is not accepted
        start = 1'b1;
        AluOP = 4'd5;
        X = $urandom;
        Y = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("add_busy", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;
        check("add_hi", HI, m_hi);
        check("add_lo", LO, m_lo);

        hi_we = 1'b1;
        wdata = 32'h55;
        tick();
        hi_we = 1'b0;
        check("mthi", HI, 32'h55);
        check("mthi_lo", LO, m_lo);
        m_hi = 32'h55;

        // MTHI/MTLO on the accepting edge: applied, then overwritten
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        accept(4'd4, 32'd1000, 32'd33);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_acc_hi", HI, 32'hDEAD_BEEF);
        check("mt_acc_lo", LO, 32'hDEAD_BEEF);
        wait_done();

        // Random back-to-back operations
        for (int n = 0; n < 24; n++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50)
                                             : $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = $urandom_range(1, 20);
                2: y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            accept(op, x, y);
            wait_done();
        end

        tick();
        tick();
        check("sb_drain", sbq.size(), 32'd0);
        check("final_hi", HI, m_hi);
        check("final_lo", LO, m_lo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
